// File: rtl/ex_stage.sv
// MIPS32 execute stage: logic/shift/move datapath, HI/LO moves and
// a restoring sequential divider that stalls the pipeline while busy.
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              mem_whilo_i,
    input  logic [DATA_W-1:0] mem_hi_i,
    input  logic [DATA_W-1:0] mem_lo_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_MOVE  = 3'b011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [DATA_W-1:0] hi_e, lo_e;
    logic [DATA_W-1:0] logic_res, shift_res, move_res;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] quo, dsor, prem;
    logic              qneg, rneg;

    logic              is_div, is_sdiv;
    logic [DATA_W-1:0] abs1, abs2;
    logic [DATA_W:0]   trial, diff;
    logic [DATA_W-1:0] q_fix, r_fix;

    assign hi_e = mem_whilo_i ? mem_hi_i : hi_i;
    assign lo_e = mem_whilo_i ? mem_lo_i : lo_i;

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        move_res = '0;
        case (aluop_i)
            OP_MFHI: move_res = hi_e;
            OP_MFLO: move_res = lo_e;
            OP_MOVZ: move_res = reg1_i;
            OP_MOVN: move_res = reg1_i;
            default: move_res = '0;
        endcase
    end

    // Divider works on magnitudes; signs are reapplied at DONE.
    assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv = (aluop_i == OP_DIV);
    assign abs1    = (is_sdiv && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign abs2    = (is_sdiv && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    assign trial   = {prem, quo[DATA_W-1]};
    assign diff    = trial - {1'b0, dsor};
    assign q_fix   = qneg ? -quo : quo;
    assign r_fix   = rneg ? -prem : prem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            quo   <= '0;
            dsor  <= '0;
            prem  <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
        end else if (annul_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div && reg2_i == '0) begin
                        quo   <= '0;
                        prem  <= '0;
                        qneg  <= 1'b0;
                        rneg  <= 1'b0;
                        state <= S_DONE;
                    end else if (is_div) begin
                        quo   <= abs1;
                        dsor  <= abs2;
                        prem  <= '0;
                        qneg  <= is_sdiv && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        rneg  <= is_sdiv && reg1_i[DATA_W-1];
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!diff[DATA_W]) begin
                        prem <= diff[DATA_W-1:0];
                        quo  <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        prem <= trial[DATA_W-1:0];
                        quo  <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DIV_CYCLES - 1))
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;

        if (aluop_i == OP_MOVZ)
            wreg_o = (reg2_i == '0);
        else if (aluop_i == OP_MOVN)
            wreg_o = (reg2_i != '0);

        case (alusel_i)
            RES_LOGIC: wdata_o = logic_res;
            RES_SHIFT: wdata_o = shift_res;
            RES_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
        endcase

        if (state == S_DONE) begin
            whilo_o = 1'b1;
            hi_o    = r_fix;
            lo_o    = q_fix;
        end else if (aluop_i == OP_MTHI) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_e;
        end else if (aluop_i == OP_MTLO) begin
            whilo_o = 1'b1;
            hi_o    = hi_e;
            lo_o    = reg1_i;
        end

        stallreq_o = (state == S_BUSY) || (state == S_IDLE && is_div);

        // A flush kills both the stall and any HI/LO write this cycle.
        if (annul_i) begin
            stallreq_o = 1'b0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
        end

        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised self-checking bench for ex_stage against a behavioural
// model of the ALU, HI/LO moves and signed/unsigned divide.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi, lo;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        annul;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ops [13] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL,
                             OP_SRL, OP_SRA, OP_MOVZ, OP_MOVN, OP_MFHI,
                             OP_MFLO, OP_MTHI, OP_MTLO};
    logic [2:0] sels [13] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC,
                              SEL_SHIFT, SEL_SHIFT, SEL_SHIFT, SEL_MOVE,
                              SEL_MOVE, SEL_MOVE, SEL_MOVE, SEL_NOP,
                              SEL_NOP};

    always #5 clk = ~clk;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop),
        .alusel_i    (alusel),
        .reg1_i      (reg1),
        .reg2_i      (reg2),
        .wd_i        (wd),
        .wreg_i      (wreg),
        .hi_i        (hi),
        .lo_i        (lo),
        .mem_whilo_i (mem_whilo),
        .mem_hi_i    (mem_hi),
        .mem_lo_i    (mem_lo),
        .annul_i     (annul),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .stallreq_o  (stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
    endtask

    // Reference for every single-cycle op, straight from the op semantics.
    task automatic check_comb();
        logic [31:0] he, le, res, ewd, eh, el;
        logic        ewr, ew;
        he  = mem_whilo ? mem_hi : hi;
        le  = mem_whilo ? mem_lo : lo;
        res = 32'h0;
        ewr = wreg;
        ew  = 1'b0;
        eh  = 32'h0;
        el  = 32'h0;
        case (aluop)
            OP_AND:  res = reg1 & reg2;
            OP_OR:   res = reg1 | reg2;
            OP_XOR:  res = reg1 ^ reg2;
            OP_NOR:  res = ~(reg1 | reg2);
            OP_SLL:  res = reg2 << reg1[4:0];
            OP_SRL:  res = reg2 >> reg1[4:0];
            OP_SRA:  res = $signed(reg2) >>> reg1[4:0];
            OP_MFHI: res = he;
            OP_MFLO: res = le;
            OP_MOVZ: begin res = reg1; ewr = (reg2 == 0); end
            OP_MOVN: begin res = reg1; ewr = (reg2 != 0); end
            OP_MTHI: begin ew = 1'b1; eh = reg1; el = le; end
            OP_MTLO: begin ew = 1'b1; eh = he; el = reg1; end
            default: res = 32'h0;
        endcase
        ewd = (alusel == SEL_NOP) ? 32'h0 : res;
        chk("wdata", wdata_o, ewd);
        chk("wreg", {31'b0, wreg_o}, {31'b0, ewr});
        chk("wd", {27'b0, wd_o}, {27'b0, wd});
        chk("whilo", {31'b0, whilo_o}, {31'b0, ew});
        if (ew) begin
            chk("hi", hi_o, eh);
            chk("lo", lo_o, el);
        end
    endtask

    // Starts at posedge+1, returns at the negedge of the result cycle.
    task automatic do_div(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int          n;
        longint      sa, sb, q, r;
        logic [31:0] eq, er;
        drive(op, SEL_NOP, a, b);
        if (b == 0) begin
            eq = 0;
            er = 0;
        end else if (op == OP_DIVU) begin
            eq = a / b;
            er = a % b;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            eq = q[31:0];
            er = r[31:0];
        end
        n = 0;
        @(negedge clk);
        while (stallreq_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("div_stall_cycles", n, (b == 0) ? 32'd1 : 32'd33);
        chk("div_whilo", {31'b0, whilo_o}, 32'd1);
        chk("div_lo", lo_o, eq);
        chk("div_hi", hi_o, er);
    endtask

    task automatic quiet_window(input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo_o || stallreq_o) pulses++;
        end
        chk(tag, pulses, 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [7:0]  op;
        int          k;

        rst = 1'b1; annul = 1'b0;
        drive(OP_OR, SEL_LOGIC, 32'hFFFF, 32'h1);
        wd = 5'd5; wreg = 1'b1;
        hi = 0; lo = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wreg", {31'b0, wreg_o}, 0);
        chk("rst_wd", {27'b0, wd_o}, 0);
        chk("rst_whilo", {31'b0, whilo_o}, 0);
        chk("rst_stall", {31'b0, stallreq_o}, 0);
        chk("rst_hilo", hi_o | lo_o, 0);

        @(posedge clk); #1;
        rst = 1'b0;
        drive(OP_OR, SEL_LOGIC, 32'h0000F0F0, 32'h00000F0F);
        @(negedge clk);
        chk("or_wdata", wdata_o, 32'h0000FFFF);
        chk("or_wd", {27'b0, wd_o}, 32'd5);
        chk("or_wreg", {31'b0, wreg_o}, 32'd1);

        @(posedge clk); #1;
        drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h80000010);
        @(negedge clk);
        chk("sra", wdata_o, 32'hF8000001);
        @(posedge clk); #1;
        drive(OP_MOVZ, SEL_MOVE, 32'h1234, 32'd0);
        @(negedge clk);
        chk("movz_zero", {31'b0, wreg_o}, 32'd1);
        @(posedge clk); #1;
        reg2 = 32'd3;
        @(negedge clk);
        chk("movz_nz", {31'b0, wreg_o}, 32'd0);

        @(posedge clk); #1;
        hi = 32'h11; mem_whilo = 1'b1; mem_hi = 32'h22; mem_lo = 32'h33;
        drive(OP_MFHI, SEL_MOVE, 0, 0);
        @(negedge clk);
        chk("mfhi_fwd", wdata_o, 32'h22);
        @(posedge clk); #1;
        drive(OP_MTLO, SEL_NOP, 32'h55, 0);
        @(negedge clk);
        chk("mtlo_whilo", {31'b0, whilo_o}, 32'd1);
        chk("mtlo_lo", lo_o, 32'h55);
        chk("mtlo_hi", hi_o, 32'h22);

        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            k = $urandom_range(0, 12);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            drive(ops[k], sels[k], a, b);
            if (k < 11 && $urandom_range(0, 7) == 0) alusel = SEL_NOP;
            wd = 5'($urandom); wreg = 1'($urandom);
            hi = $urandom; lo = $urandom;
            mem_hi = $urandom; mem_lo = $urandom;
            mem_whilo = 1'($urandom);
            @(negedge clk);
            check_comb();
        end

        @(posedge clk); #1;
        wreg = 1'b0;
        do_div(OP_DIV, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); #1;
        do_div(OP_DIVU, 32'hFFFFFFFF, 32'h10);
        @(posedge clk); #1;
        do_div(OP_DIVU, 32'h1234, 32'h0);
        @(posedge clk); #1;
        do_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        @(posedge clk); #1;
        drive(OP_NOP, SEL_NOP, 0, 0);
        @(negedge clk);
        chk("div_one_pulse", {31'b0, whilo_o}, 0);

        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            op = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            do_div(op, a, b);
        end

        @(posedge clk); #1;
        drive(OP_DIV, SEL_NOP, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_stall", {31'b0, stallreq_o}, 0);
        chk("annul_whilo", {31'b0, whilo_o}, 0);
        @(posedge clk); #1;
        annul = 1'b0;
        drive(OP_NOP, SEL_NOP, 0, 0);
        quiet_window("annul_no_wb");

        @(posedge clk); #1;
        wreg = 1'b1; wd = 5'd9;
        drive(OP_DIV, SEL_NOP, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstdiv_stall", {31'b0, stallreq_o}, 0);
        chk("rstdiv_out", {wd_o, wreg_o, whilo_o} | hi_o | lo_o | wdata_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(OP_NOP, SEL_NOP, 0, 0);
        quiet_window("rst_no_wb");
        @(posedge clk); #1;
        do_div(OP_DIV, 32'hFFFFFF9C, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
